kronos_if_prefetch: RTL and testbench



---
 rtl/kronos_types.sv | 18 +
 rtl/kronos_fetch_fifo.sv | 62 ++++++
 rtl/kronos_if_prefetch.sv | 105 ++++++++++
 tb/tb_kronos_if_prefetch.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kronos_types.sv
// Shared types and constants for the Kronos fetch front end.
package kronos_types;

    // IF/ID pipe register contents: fetch address and instruction word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } pipeIFID_t;

    // Canonical no-op (addi x0, x0, 0).
    localparam logic [31:0] INSTR_NOP = 32'h00000013;

    // Clear the byte-offset bits of an address so it lands on a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/kronos_fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of {pc, ir} pairs with a one-cycle flush.
// Head data reads as zero while the buffer is empty.
module kronos_fetch_fifo
    import kronos_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  pipeIFID_t                  wdata,
    input  logic                       pop,
    input  logic                       flush,
    output pipeIFID_t                  head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    pipeIFID_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Write the incoming entry into the slot at the write pointer.
    // NOTE: storage has no reset; count/pointers alone decide which slots are valid,
    // so resetting the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Advance pointers and occupancy; flush drops every entry at once.
    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/kronos_if_prefetch.sv
// Instruction fetch stage with prefetch buffer and multiple outstanding IMEM requests.
// Requests are issued only when a response slot is guaranteed in the buffer, because
// IMEM responses cannot be back-pressured. A branch redirects fetch, empties the
// buffer and marks every in-flight response to be dropped on arrival.
module kronos_if_prefetch
    import kronos_types::*;
#(
    parameter logic [31:0] PC_START        = 32'h0,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instr_addr,
    output logic        instr_req,
    input  logic        instr_gnt,
    input  logic        instr_rvalid,
    input  logic [31:0] instr_rdata,
    output pipeIFID_t   pipe_IFID,
    output logic        pipe_vld,
    input  logic        pipe_rdy,
    input  logic        branch,
    input  logic [31:0] branch_target
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = ((CW > OW) ? CW : OW) + 1;

    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_push;
    logic          fifo_pop;
    logic          accept;
    logic [SW-1:0] inflight;
    logic [31:0]   target;
    pipeIFID_t     fifo_wdata;

    assign target     = align_word(branch_target);
    assign inflight   = SW'(outstanding) + SW'(fifo_count);
    assign instr_req  = !rst && !branch
                        && (outstanding < OW'(MAX_OUTSTANDING))
                        && (inflight < SW'(FIFO_DEPTH));
    assign instr_addr = pc;
    assign accept     = instr_req && instr_gnt;

    assign fifo_push  = instr_rvalid && !branch && (discard == '0);
    assign fifo_pop   = pipe_vld && pipe_rdy;
    assign fifo_wdata = '{pc: resp_pc, ir: instr_rdata};
    assign pipe_vld   = !fifo_empty;

    // Track fetch/response addresses and the in-flight and to-be-dropped counts.
    // outstanding already includes responses that are marked for dropping, so after a
    // branch every still-pending response is stale and discard becomes outstanding
    // minus the one that lands this cycle; back-to-back branches cannot double count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= PC_START;
            resp_pc     <= PC_START;
            outstanding <= '0;
            discard     <= '0;
        end else if (branch) begin
            pc          <= target;
            resp_pc     <= target;
            outstanding <= outstanding - OW'(instr_rvalid);
            discard     <= outstanding - OW'(instr_rvalid);
        end else begin
            if (accept) begin
                pc <= pc + 32'd4;
            end
            outstanding <= outstanding + OW'(accept) - OW'(instr_rvalid);
            if (instr_rvalid) begin
                if (discard != '0) begin
                    discard <= discard - OW'(1);
                end else begin
                    resp_pc <= resp_pc + 32'd4;
                end
            end
        end
    end

    kronos_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .flush (branch),
        .head  (pipe_IFID),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // The credit check must keep every accepted response room in the buffer.
    assert property (@(posedge clk) disable iff (rst) fifo_push |-> (!fifo_full || fifo_pop));

endmodule

// File: tb/tb_kronos_if_prefetch.sv
// Scoreboard bench for the prefetching fetch stage: a randomised IMEM model issues
// responses, a reference model predicts the instruction stream ID must see, and a
// separate monitor compares every ID handshake against the predicted queue.
module tb_kronos_if_prefetch;
    import kronos_types::*;

    localparam logic [31:0] PC_START = 32'h0;
    localparam int          DEPTH    = 4;
    localparam int          MAXO     = 2;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    logic        clk;
    logic        rst;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    pipeIFID_t   pipe_IFID;
    logic        pipe_vld;
    logic        pipe_rdy;
    logic        branch;
    logic [31:0] branch_target;

    kronos_if_prefetch #(
        .PC_START        (PC_START),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_addr    (instr_addr),
        .instr_req     (instr_req),
        .instr_gnt     (instr_gnt),
        .instr_rvalid  (instr_rvalid),
        .instr_rdata   (instr_rdata),
        .pipe_IFID     (pipe_IFID),
        .pipe_vld      (pipe_vld),
        .pipe_rdy      (pipe_rdy),
        .branch        (branch),
        .branch_target (branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    req_t        pend[$];      // accepted, unanswered IMEM requests
    pipeIFID_t   exp_q[$];     // instructions ID should receive, in order
    logic [31:0] model_pc;
    int          epoch;
    int          cyc;
    int          acc_cnt;
    int          hs_cnt;
    int          first_acc;
    int          first_vld;
    int          bad_200;
    logic        prev_stall;
    logic [31:0] prev_addr;

    // Stimulus knobs
    int          gnt_prob;
    int          rdy_prob;
    int          lat_min;
    int          lat_max;
    logic        br_now;
    logic [31:0] br_tgt;

    int          n_tests;
    int          n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive at +1, monitor compares at +2, reference model steps at +3.
    task automatic cycle();
        logic resp;
        req_t r;
        pipeIFID_t e;
        int lat;
        @(posedge clk);
        #1;
        instr_gnt     = ($urandom_range(99) < gnt_prob);
        resp          = (pend.size() != 0) && (pend[0].due <= cyc);
        instr_rvalid  = resp;
        instr_rdata   = resp ? mem_word(pend[0].addr) : $urandom();
        pipe_rdy      = ($urandom_range(99) < rdy_prob);
        branch        = br_now;
        branch_target = br_tgt;
        #2;
        check("instr_addr", {32'h0, instr_addr}, {32'h0, model_pc});
        if (branch) begin
            check("req_in_branch", {63'h0, instr_req}, 64'h0);
        end else if (prev_stall) begin
            check("req_held", {63'h0, instr_req}, 64'h1);
            check("addr_held", {32'h0, instr_addr}, {32'h0, prev_addr});
        end
        check("outstanding_limit", {63'h0, pend.size() <= MAXO}, 64'h1);
        check("credit_limit", {63'h0, (pend.size() + exp_q.size()) <= DEPTH}, 64'h1);
        if (pipe_vld && pipe_rdy) hs_cnt++;
        if (pipe_vld && first_vld < 0) first_vld = cyc;
        prev_stall = instr_req && !instr_gnt;
        prev_addr  = instr_addr;
        if (instr_req && instr_gnt) begin
            if (first_acc < 0) first_acc = cyc;
            lat = int'($urandom_range(lat_max, lat_min));
            pend.push_back('{addr: model_pc, epoch: epoch, due: cyc + lat});
            model_pc += 32'd4;
            acc_cnt++;
        end
        if (resp) begin
            r = pend.pop_front();
            if (r.epoch == epoch && !branch) begin
                e.pc = r.addr;
                e.ir = mem_word(r.addr);
                exp_q.push_back(e);
            end
        end
        if (branch) begin
            epoch++;
            exp_q.delete();
            model_pc = {br_tgt[31:2], 2'b00};
        end
        br_now = 1'b0;
        cyc++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst          = 1'b1;
        instr_gnt    = 1'b0;
        instr_rvalid = 1'b0;
        pipe_rdy     = 1'b0;
        branch       = 1'b0;
        br_now       = 1'b0;
        pend.delete();
        exp_q.delete();
        model_pc   = PC_START;
        epoch++;
        prev_stall = 1'b0;
        acc_cnt    = 0;
        hs_cnt     = 0;
        first_acc  = -1;
        first_vld  = -1;
        #1;
        check("rst_pipe_vld", {63'h0, pipe_vld}, 64'h0);
        check("rst_instr_req", {63'h0, instr_req}, 64'h0);
        check("rst_instr_addr", {32'h0, instr_addr}, {32'h0, PC_START});
        check("rst_pipe_IFID", pipe_IFID, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Step until the buffer presents an entry, then compare it with the expected head.
    task automatic wait_head(input string name, input logic [31:0] pc_exp);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            cycle();
            if (pipe_vld) begin
                got = 1'b1;
                check({name, "_pc"}, {32'h0, pipe_IFID.pc}, {32'h0, pc_exp});
                check({name, "_ir"}, {32'h0, pipe_IFID.ir}, {32'h0, mem_word(pc_exp)});
            end
        end
        check({name, "_timeout"}, {63'h0, got}, 64'h1);
    endtask

    // Monitor: on every ID handshake, pop the scoreboard and compare.
    initial begin
        pipeIFID_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                check("pipe_vld", {63'h0, pipe_vld}, {63'h0, exp_q.size() != 0});
                if (pipe_vld && pipe_rdy) begin
                    if (pipe_IFID.pc >= 32'h200 && pipe_IFID.pc < 32'h300) bad_200++;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL pop_unexpected: got %h expected no entry", pipe_IFID);
                    end else begin
                        e = exp_q.pop_front();
                        check("pipe_IFID", pipe_IFID, e);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  h0;
        int  a0;
        logic found;
        rst = 1'b1;
        instr_gnt = 1'b0; instr_rvalid = 1'b0; instr_rdata = '0;
        pipe_rdy = 1'b0; branch = 1'b0; branch_target = '0;
        br_now = 1'b0; br_tgt = '0;
        n_tests = 0; n_fail = 0; epoch = 0; cyc = 0; bad_200 = 0;
        gnt_prob = 100; rdy_prob = 100; lat_min = 1; lat_max = 1;

        // Streaming at full rate
        do_reset();
        repeat (10) cycle();
        check("first_vld_latency", 64'(first_vld - first_acc), 64'd2);
        h0 = hs_cnt;
        repeat (20) cycle();
        check("throughput", 64'(hs_cnt - h0), 64'd20);

        // Backpressure fills the buffer, then one pop frees exactly one fetch
        do_reset();
        rdy_prob = 0;
        repeat (12) cycle();
        check("bp_accepts", 64'(acc_cnt), 64'd4);
        check("bp_req_low", {63'h0, instr_req}, 64'h0);
        check("bp_addr", {32'h0, instr_addr}, 64'h10);
        rdy_prob = 100;
        cycle();
        rdy_prob = 0;
        repeat (6) cycle();
        check("bp_one_more", 64'(acc_cnt), 64'd5);
        check("bp_addr2", {32'h0, instr_addr}, 64'h14);

        // Grant stall mid-stream
        do_reset();
        rdy_prob = 100;
        repeat (6) cycle();
        a0 = acc_cnt;
        gnt_prob = 0;
        repeat (5) begin
            cycle();
            check("stall_req", {63'h0, instr_req}, 64'h1);
        end
        gnt_prob = 100;
        cycle();
        check("stall_accept", 64'(acc_cnt - a0), 64'd1);
        repeat (10) cycle();

        // Branch with two responses (0x8, 0xC) still in flight
        do_reset();
        lat_min = 4; lat_max = 4;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (pend.size() == 2 && pend[0].addr == 32'h8 && pend[1].addr == 32'hC) found = 1'b1;
        end
        check("flush_setup", {63'h0, found}, 64'h1);
        lat_min = 1; lat_max = 1;
        br_now = 1'b1; br_tgt = 32'h100;
        cycle();
        wait_head("flush_head", 32'h100);
        repeat (10) cycle();

        // Back-to-back branches with responses pending
        do_reset();
        lat_min = 3; lat_max = 3;
        repeat (4) cycle();
        bad_200 = 0;
        br_now = 1'b1; br_tgt = 32'h200;
        cycle();
        br_now = 1'b1; br_tgt = 32'h300;
        cycle();
        lat_min = 1; lat_max = 3;
        wait_head("b2b_head", 32'h300);
        repeat (20) cycle();
        check("b2b_no_200", 64'(bad_200), 64'd0);

        // Unaligned target near the top of memory; fetch wraps to 0
        br_now = 1'b1; br_tgt = 32'hFFFF_FFFB;
        cycle();
        wait_head("wrap_head", 32'hFFFF_FFF8);
        repeat (10) cycle();

        // Reset in the middle of traffic with requests and entries in flight
        gnt_prob = 80; rdy_prob = 30; lat_min = 2; lat_max = 4;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle();
            if (pend.size() >= 1 && exp_q.size() >= 2) found = 1'b1;
        end
        check("midrst_setup", {63'h0, found}, 64'h1);
        do_reset();
        gnt_prob = 100; rdy_prob = 100; lat_min = 1; lat_max = 1;
        wait_head("midrst_head", PC_START);

        // Random traffic with occasional branches
        gnt_prob = 70; rdy_prob = 60; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 3) begin
                br_now = 1'b1;
                br_tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                  : $urandom();
            end
            cycle();
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
